// File: rtl/phase_pkg.sv
// Shared types and constant helpers for the phase unwrapper.
package phase_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_e;

  // One full turn in phase codes, where pi is the code for +pi.
  function automatic longint full_turn(input longint pi);
    return 2 * (pi + 1);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/phase_unwrap_if.sv
// Sample/result bundle between the CORDIC phase stage, the unwrapper and the readout path.
interface phase_unwrap_if #(
  parameter int BIT_WIDTH_IN  = 27,
  parameter int BIT_WIDTH_OUT = 40,
  parameter int WRAP_W        = 16
) ();

  logic signed [BIT_WIDTH_IN-1:0]  phi_i;
  logic                            done_i;
  logic                            clear_i;
  logic signed [BIT_WIDTH_OUT-1:0] phi_o;
  logic                            valid_o;
  logic signed [WRAP_W-1:0]        wraps_o;
  logic                            sat_o;

  modport master (
    output phi_i, done_i, clear_i,
    input  phi_o, valid_o, wraps_o, sat_o
  );

  modport slave (
    input  phi_i, done_i, clear_i,
    output phi_o, valid_o, wraps_o, sat_o
  );

endinterface

// File: rtl/phase_unwrap.sv
// Phase unwrapper: removes 2*pi steps from the wrapped CORDIC phase and accumulates
// a continuous signed phase, with a saturating net wrap count and sticky rail flag.
//
// state | meaning
// EMPTY | no previous sample; next accepted sample seeds the accumulator
// TRACK | previous sample held; next sample is unwrapped against it
module phase_unwrap
  import phase_pkg::*;
#(
  parameter int BIT_WIDTH_IN  = 27,
  parameter int BIT_WIDTH_OUT = 40,
  parameter int PI            = 8388607,
  parameter int WRAP_W        = 16
) (
  input logic           clk_i,
  input logic           reset_i,
  phase_unwrap_if.slave bus
);

  localparam int DW = BIT_WIDTH_IN + 2;
  localparam int SW = ((BIT_WIDTH_OUT > BIT_WIDTH_IN) ? BIT_WIDTH_OUT : BIT_WIDTH_IN) + 2;

  localparam logic signed [DW-1:0]     PI_D    = DW'(PI);
  localparam logic signed [DW-1:0]     TURN_D  = DW'(full_turn(PI));
  localparam logic signed [SW-1:0]     ACC_MAX = SW'(sat_max(BIT_WIDTH_OUT));
  localparam logic signed [SW-1:0]     ACC_MIN = SW'(sat_min(BIT_WIDTH_OUT));
  localparam logic signed [WRAP_W-1:0] WR_MAX  = WRAP_W'(sat_max(WRAP_W));
  localparam logic signed [WRAP_W-1:0] WR_MIN  = WRAP_W'(sat_min(WRAP_W));

  state_e state_q, state_d;
  logic   done_q;
  logic   sample;

  logic signed [BIT_WIDTH_IN-1:0] prev_q;
  logic signed [DW-1:0]           d_raw, d_next;
  logic                           inc_next, dec_next;

  logic                 s1_valid_q, s1_seed_q, s1_inc_q, s1_dec_q;
  logic signed [DW-1:0] s1_d_q;

  logic signed [SW-1:0]            base, sum;
  logic signed [BIT_WIDTH_OUT-1:0] acc_q, acc_next;
  logic                            clamp;
  logic signed [WRAP_W-1:0]        wraps_q, wraps_next;
  logic                            sat_q, valid_q;

  assign sample = bus.done_i & ~done_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Clear beats a coincident sample edge, so that sample never seeds TRACK.
  always_comb begin
    state_d = state_q;
    if (bus.clear_i)  state_d = EMPTY;
    else if (sample)  state_d = TRACK;
  end

  always_comb begin
    d_raw    = DW'(bus.phi_i) - DW'(prev_q);
    d_next   = d_raw;
    inc_next = 1'b0;
    dec_next = 1'b0;
    if (state_q == EMPTY) begin
      d_next = DW'(bus.phi_i);
    end else if (d_raw > PI_D) begin
      d_next   = d_raw - TURN_D;
      dec_next = 1'b1;
    end else if (d_raw < -PI_D) begin
      d_next   = d_raw + TURN_D;
      inc_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      done_q     <= 1'b0;
      prev_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_seed_q  <= 1'b0;
      s1_inc_q   <= 1'b0;
      s1_dec_q   <= 1'b0;
      s1_d_q     <= '0;
    end else begin
      done_q <= bus.done_i;
      if (bus.clear_i) begin
        prev_q     <= '0;
        s1_valid_q <= 1'b0;
        s1_inc_q   <= 1'b0;
        s1_dec_q   <= 1'b0;
      end else begin
        s1_valid_q <= sample;
        if (sample) begin
          prev_q    <= bus.phi_i;
          s1_d_q    <= d_next;
          s1_seed_q <= (state_q == EMPTY);
          s1_inc_q  <= inc_next;
          s1_dec_q  <= dec_next;
        end
      end
    end
  end

  // A seed sample starts from zero rather than the held accumulator.
  always_comb begin
    base = SW'(acc_q);
    if (s1_seed_q) base = '0;
    sum      = base + SW'(s1_d_q);
    acc_next = BIT_WIDTH_OUT'(sum);
    clamp    = 1'b0;
    if (sum > ACC_MAX) begin
      acc_next = BIT_WIDTH_OUT'(ACC_MAX);
      clamp    = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_next = BIT_WIDTH_OUT'(ACC_MIN);
      clamp    = 1'b1;
    end
  end

  always_comb begin
    wraps_next = wraps_q;
    if (s1_inc_q && (wraps_q != WR_MAX))      wraps_next = wraps_q + WRAP_W'(1);
    else if (s1_dec_q && (wraps_q != WR_MIN)) wraps_next = wraps_q - WRAP_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      acc_q   <= '0;
      wraps_q <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.clear_i) begin
      acc_q   <= '0;
      wraps_q <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        acc_q   <= acc_next;
        wraps_q <= wraps_next;
        if (clamp) sat_q <= 1'b1;
      end
    end
  end

  assign bus.phi_o   = acc_q;
  assign bus.wraps_o = wraps_q;
  assign bus.sat_o   = sat_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_phase_unwrap.sv
// Directed bench for phase_unwrap: vector table plus hand sequences for hold, clear and reset.
module tb_phase_unwrap;

  localparam int IN_W  = 27;
  localparam int OUT_W = 26;
  localparam int PI_C  = 8388607;
  localparam int WR_W  = 16;

  typedef struct {
    bit     clr;
    int     phi;
    longint exp_phi;
    int     exp_wraps;
    bit     exp_sat;
  } vec_t;

  logic clk;
  logic reset_i;
  int   n_pass;
  int   n_total;
  vec_t vecs[$];

  phase_unwrap_if #(.BIT_WIDTH_IN(IN_W), .BIT_WIDTH_OUT(OUT_W), .WRAP_W(WR_W)) bus ();

  phase_unwrap #(
    .BIT_WIDTH_IN (IN_W),
    .BIT_WIDTH_OUT(OUT_W),
    .PI           (PI_C),
    .WRAP_W       (WR_W)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
  endtask

  task automatic apply(input string tag, input int phi, input longint ep, input int ew, input bit es);
    @(negedge clk);
    bus.phi_i  = IN_W'(phi);
    bus.done_i = 1'b1;
    @(negedge clk);
    bus.done_i = 1'b0;
    check({tag, " early valid"}, longint'(bus.valid_o), 0);
    @(negedge clk);
    check({tag, " valid"}, longint'(bus.valid_o), 1);
    check({tag, " phi"},   longint'(bus.phi_o), ep);
    check({tag, " wraps"}, longint'(bus.wraps_o), longint'(ew));
    check({tag, " sat"},   longint'(bus.sat_o), longint'(es));
  endtask

  task automatic count_valid(input int cycles, output int cnt, output longint last);
    cnt  = 0;
    last = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        cnt++;
        last = longint'(bus.phi_o);
      end
    end
  endtask

  initial begin
    int     cnt;
    longint last;
    n_pass  = 0;
    n_total = 0;

    vecs.push_back(vec_t'{1'b0,     1000,     1000,  0, 1'b0});
    vecs.push_back(vec_t'{1'b1,  8000000,  8000000,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0, -8000000,  8777216,  1, 1'b0});
    vecs.push_back(vec_t'{1'b1, -8000000, -8000000,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0,  8000000, -8777216, -1, 1'b0});
    vecs.push_back(vec_t'{1'b1,        0,        0,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0,  8388607,  8388607,  0, 1'b0});
    vecs.push_back(vec_t'{1'b1,        0,        0,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0, -8388607, -8388607,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0,  8388607, -8388609, -1, 1'b0});
    vecs.push_back(vec_t'{1'b1,  8388607,  8388607,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0,       -1, 16777215,  1, 1'b0});
    // Monotonic climb into the 26-bit positive rail, then a step back down.
    vecs.push_back(vec_t'{1'b1,        0,        0,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0,  8000000,  8000000,  0, 1'b0});
    vecs.push_back(vec_t'{1'b0, -8000000,  8777216,  1, 1'b0});
    vecs.push_back(vec_t'{1'b0,        0, 16777216,  1, 1'b0});
    vecs.push_back(vec_t'{1'b0,  8000000, 24777216,  1, 1'b0});
    vecs.push_back(vec_t'{1'b0, -8000000, 25554432,  2, 1'b0});
    vecs.push_back(vec_t'{1'b0,        0, 33554431,  2, 1'b1});
    vecs.push_back(vec_t'{1'b0, -8000000, 25554431,  2, 1'b1});
    vecs.push_back(vec_t'{1'b1,      100,      100,  0, 1'b0});

    reset_i     = 1'b0;
    bus.phi_i   = '0;
    bus.done_i  = 1'b0;
    bus.clear_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset phi",   longint'(bus.phi_o), 0);
    check("reset valid", longint'(bus.valid_o), 0);
    check("reset wraps", longint'(bus.wraps_o), 0);
    check("reset sat",   longint'(bus.sat_o), 0);
    reset_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].clr) pulse_clear();
      apply($sformatf("vec%0d", i), vecs[i].phi, vecs[i].exp_phi, vecs[i].exp_wraps, vecs[i].exp_sat);
    end

    // done_i held high for several cycles yields one sample.
    pulse_clear();
    @(negedge clk);
    bus.phi_i  = IN_W'(500);
    bus.done_i = 1'b1;
    count_valid(5, cnt, last);
    bus.done_i = 1'b0;
    begin
      int     cnt2;
      longint last2;
      count_valid(4, cnt2, last2);
      check("hold valid count", longint'(cnt + cnt2), 1);
    end
    check("hold phi", last, 500);

    // Clear coincident with a sample edge drops that sample.
    @(negedge clk);
    bus.phi_i   = IN_W'(7777);
    bus.done_i  = 1'b1;
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.done_i  = 1'b0;
    bus.clear_i = 1'b0;
    count_valid(4, cnt, last);
    check("coincident clear valid count", longint'(cnt), 0);

    // Clear while a sample sits in stage 1 discards it.
    @(negedge clk);
    bus.phi_i  = IN_W'(6666);
    bus.done_i = 1'b1;
    @(negedge clk);
    bus.done_i  = 1'b0;
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    check("inflight clear valid", longint'(bus.valid_o), 0);
    count_valid(3, cnt, last);
    check("inflight clear valid count", longint'(cnt), 0);
    check("inflight clear phi", longint'(bus.phi_o), 0);

    apply("reseed", 1234, 1234, 0, 1'b0);
    apply("pre-reset a", 8000000, 8000000, 0, 1'b0);
    apply("pre-reset b", -8000000, 8777216, 1, 1'b0);

    // Reset asserted with a sample in flight.
    @(negedge clk);
    bus.phi_i  = IN_W'(42);
    bus.done_i = 1'b1;
    @(negedge clk);
    bus.done_i = 1'b0;
    reset_i    = 1'b0;
    #1;
    check("midreset phi",   longint'(bus.phi_o), 0);
    check("midreset valid", longint'(bus.valid_o), 0);
    check("midreset wraps", longint'(bus.wraps_o), 0);
    check("midreset sat",   longint'(bus.sat_o), 0);
    @(negedge clk);
    reset_i = 1'b1;
    count_valid(5, cnt, last);
    check("post-reset valid count", longint'(cnt), 0);
    check("post-reset phi", longint'(bus.phi_o), 0);

    apply("after reset", 300, 300, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
